memory_port_arbiter: RTL

// Shares the single unified memory port between instruction fetch (I) and data access (D, MEM stage).

---
 rtl/memory_port_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/memory_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and data access.
// Data has priority, bounded by a starvation counter; a grant timeout raises a sticky bus error.
module memory_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  I_Req,
  input  logic [ADDR_W-1:0]     I_Addr,
  output logic                  I_Ready,
  output logic [DATA_W-1:0]     I_R_Data,
  input  logic                  D_Req,
  input  logic                  D_W_En,
  input  logic [ADDR_W-1:0]     D_Addr,
  input  logic [DATA_W/8-1:0]   D_Byte_En,
  input  logic [DATA_W-1:0]     D_W_Data,
  output logic                  D_Ready,
  output logic [DATA_W-1:0]     D_R_Data,
  output logic                  Mem_Req,
  output logic                  Mem_W_En,
  output logic [ADDR_W-1:0]     Mem_Addr,
  output logic [DATA_W/8-1:0]   Mem_Byte_En,
  output logic [DATA_W-1:0]     Mem_W_Data,
  input  logic                  Mem_Ack,
  input  logic [DATA_W-1:0]     Mem_R_Data,
  output logic                  Stall_Mem,
  output logic                  Bus_Err
);

  localparam int WAIT_W   = $clog2(TIMEOUT + 1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] GNT_I = 2'b01;
  localparam logic [1:0] GNT_D = 2'b10;

  logic [1:0]          state;
  logic [STARVE_W-1:0] starve_cnt;
  logic [WAIT_W-1:0]   wait_cnt;

  logic i_pend, d_pend, i_cand, d_cand;
  logic decide, starved, pick_i, pick_d, timed_out;

  // A request whose Ready is showing is the one just served and is not yet withdrawn,
  // so it never counts as pending; the owner is also excluded in its own ack cycle.
  always_comb begin
    i_pend    = I_Req & ~I_Ready;
    d_pend    = D_Req & ~D_Ready;
    i_cand    = i_pend & (state != GNT_I);
    d_cand    = d_pend & (state != GNT_D);
    decide    = (state == IDLE) | Mem_Ack;
    starved   = (starve_cnt == STARVE_W'(STARVE_LIMIT));
    pick_d    = d_cand & ~(i_cand & starved);
    pick_i    = i_cand & ~pick_d;
    timed_out = (state != IDLE) & ~Mem_Ack & (wait_cnt == WAIT_W'(TIMEOUT));
  end

  assign Stall_Mem = (I_Req & ~I_Ready) | (D_Req & ~D_Ready);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      Mem_Req     <= 1'b0;
      Mem_W_En    <= 1'b0;
      Mem_Addr    <= '0;
      Mem_Byte_En <= '0;
      Mem_W_Data  <= '0;
      I_Ready     <= 1'b0;
      D_Ready     <= 1'b0;
      I_R_Data    <= '0;
      D_R_Data    <= '0;
      Bus_Err     <= 1'b0;
      starve_cnt  <= '0;
      wait_cnt    <= '0;
    end else begin
      I_Ready <= 1'b0;
      D_Ready <= 1'b0;

      if (state != IDLE) begin
        if (Mem_Ack) begin
          if (state == GNT_I) begin
            I_Ready  <= 1'b1;
            I_R_Data <= Mem_R_Data;
          end else begin
            D_Ready  <= 1'b1;
            D_R_Data <= Mem_W_En ? '0 : Mem_R_Data;
          end
        end else if (timed_out) begin
          // Dead bus: release the requester with zero data so the pipeline unstalls.
          Bus_Err <= 1'b1;
          Mem_Req <= 1'b0;
          state   <= IDLE;
          if (state == GNT_I) begin
            I_Ready  <= 1'b1;
            I_R_Data <= '0;
          end else begin
            D_Ready  <= 1'b1;
            D_R_Data <= '0;
          end
        end else begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end
      end

      if (decide) begin
        if (pick_d) begin
          state       <= GNT_D;
          Mem_Req     <= 1'b1;
          Mem_W_En    <= D_W_En;
          Mem_Addr    <= D_Addr;
          Mem_Byte_En <= D_Byte_En;
          Mem_W_Data  <= D_W_Data;
          wait_cnt    <= '0;
          if (i_cand && !starved) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
          end
        end else if (pick_i) begin
          state       <= GNT_I;
          Mem_Req     <= 1'b1;
          Mem_W_En    <= 1'b0;
          Mem_Addr    <= I_Addr;
          Mem_Byte_En <= '1;
          Mem_W_Data  <= '0;
          wait_cnt    <= '0;
          starve_cnt  <= '0;
        end else begin
          state   <= IDLE;
          Mem_Req <= 1'b0;
        end
      end
    end
  end

endmodule
